// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NAND = 3'b010,
    OP_XOR  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SRA  = 3'b101,
    OP_ROR  = 3'b110,
    OP_ILL  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_mc_cla_addsub.sv
// Parallel-prefix (Kogge-Stone) carry-lookahead adder/subtractor with signed overflow.
module cla_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovfl
);
  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] bx, p0, g, p, carry;

  assign bx = b ^ {WIDTH{sub}};
  assign p0 = a ^ bx;

  // Carry-in is folded into bit 0's generate so the prefix tree yields full carries.
  always_comb begin
    g = (a & bx) | {{(WIDTH-1){1'b0}}, p0[0] & sub};
    p = p0;
    for (int l = 0; l < LV; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & ((p << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
    end
  end

  assign carry = {g[WIDTH-2:0], sub};
  assign sum   = p0 ^ carry;
  assign ovfl  = g[WIDTH-1] ^ carry[WIDTH-1];

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts, valid/ready handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  op_t              sop_q, sop_d, opc;
  logic [WIDTH-1:0] result_q, result_d, work_q, work_d;
  logic [2:0]       flags_q, flags_d;
  logic             err_q, err_d;
  logic [SHW-1:0]   cnt_q, cnt_d, amt;
  logic [WIDTH-1:0] sum, arith, imm, shifted;
  logic             ovfl, is_shift;

  assign opc      = op_t'(op);
  assign amt      = b[SHW-1:0];
  assign is_shift = (opc == OP_SLL) || (opc == OP_SRA) || (opc == OP_ROR);

  cla_addsub #(.WIDTH(WIDTH)) u_cla (
    .a    (a),
    .b    (b),
    .sub  (opc == OP_SUB),
    .sum  (sum),
    .ovfl (ovfl)
  );

  // Wrapped sum's MSB is inverted on overflow, so it tells the overflow direction.
  assign arith = (SAT && ovfl) ? (sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                               : {1'b1, {(WIDTH-1){1'b0}}})
                               : sum;

  always_comb begin
    unique case (opc)
      OP_NAND: imm = ~(a & b);
      OP_XOR:  imm = a ^ b;
      default: imm = a;
    endcase
  end

  always_comb begin
    unique case (sop_q)
      OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
      OP_SRA:  shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: shifted = {work_q[0], work_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) begin
        state_d = ST_DONE;
        err_d   = 1'b0;
        if (opc == OP_ADD || opc == OP_SUB) begin
          result_d       = arith;
          flags_d[FLG_N] = arith[WIDTH-1];
          flags_d[FLG_Z] = (arith == '0);
          flags_d[FLG_V] = ovfl;
        end else if (opc == OP_ILL) begin
          result_d = '0;
          err_d    = 1'b1;
        end else if (is_shift && amt != '0) begin
          work_d  = a;
          cnt_d   = amt;
          sop_d   = opc;
          state_d = ST_SHIFT;
        end else begin
          result_d       = imm;
          flags_d[FLG_Z] = (imm == '0);
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d       = shifted;
          flags_d[FLG_Z] = (shifted == '0);
          state_d        = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      sop_q    <= OP_SLL;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign err       = err_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal range 4..64).
REQ-002 Parameter SAT, default 1: 1 means ADD/SUB saturate on overflow, 0 means they wrap.
REQ-003 Derived constant SHW = $clog2(WIDTH), the shift-amount width; it is not overridable.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: operation request is present.
REQ-007 Port in_ready, output, 1 bit: block can accept a request.
REQ-008 Port op, input, 3 bits: opcode.
REQ-009 Port a, input, WIDTH bits: operand A.
REQ-010 Port b, input, WIDTH bits: operand B; for shifts, b[SHW-1:0] is the shift amount.
REQ-011 Port out_valid, output, 1 bit: result is present.
REQ-012 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 Port result, output, WIDTH bits: registered result.
REQ-014 Port flags, output, 3 bits: registered {N,Z,V}.
REQ-015 Port err, output, 1 bit: illegal opcode, qualified by out_valid.

Function
REQ-016 Opcode map: 000 ADD, 001 SUB (a-b), 010 NAND, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 illegal.
REQ-017 FSM states: IDLE, SHIFT, DONE.
REQ-018 in_ready = 1 only in IDLE; a request is accepted on in_valid & in_ready.
REQ-019 IDLE, accepted non-shift op: compute, register result/flags/err, go to DONE; out_valid rises the next cycle (latency 1).
REQ-020 IDLE, accepted shift op with amount 0: result = a, go to DONE (latency 1).
REQ-021 IDLE, accepted shift op with amount k>0: latch a, op and k, go to SHIFT.
REQ-022 SHIFT: each cycle shift the working register one bit and decrement the count; at count 1, write the final result, go to DONE; total latency is k+1 cycles.
REQ-023 Shift semantics: SLL fills with 0; SRA replicates the MSB; ROR moves the LSB to the MSB.
REQ-024 DONE: out_valid = 1; result, flags and err are held stable until out_valid & out_ready, then go to IDLE.
REQ-025 A new request is not accepted in the DONE cycle (no overlap); throughput is at most one op per 2 cycles.
REQ-026 ADD/SUB: signed two's complement, WIDTH-bit; V = signed overflow.
REQ-027 When SAT=1 and V=1, result = 0111..1 on positive overflow and 1000..0 on negative overflow.
REQ-028 ADD/SUB update N (result MSB), Z (result==0) and V.
REQ-029 NAND, XOR and all shifts update Z only; N and V hold their previous values.
REQ-030 op 111: result = 0, err = 1, flags unchanged; err = 0 for all legal ops.
REQ-031 Inputs are sampled only at acceptance; changes to a, b and op afterwards have no effect.

Reset
REQ-032 rst_n low forces state = IDLE, result = 0, flags = 000, err = 0, out_valid = 0, and the shift count = 0.
REQ-033 Reset mid-SHIFT or mid-DONE aborts the operation; no result is delivered after reset release.
REQ-034 in_ready = 1 in the first cycle after reset deassertion.

Structure
REQ-035 Package alu_pkg holds the opcode enum (op_t), the FSM state enum (state_t) and the flag-bit index constants.
REQ-036 Sub-module cla_addsub #(WIDTH) (inputs a, b, sub; outputs sum, ovfl) is a parametrised carry-lookahead add/subtract used for ADD/SUB.
REQ-037 All outputs are driven from registers; there is no combinational path from inputs to result, flags or err.

Verification (WIDTH=16)
REQ-038 SAT=1, ADD a=7FFF b=0001 -> result 7FFF, flags N=0 Z=0 V=1, out_valid 1 cycle after acceptance.
REQ-039 SAT=0, SUB a=8000 b=0001 -> result 7FFF, V=1, N=0; then XOR a=b=1234 -> result 0000, Z=1, V still 1.
REQ-040 SRA a=8000 b=0004 -> result F800 after 5 cycles, in_ready low throughout; ROR a=0001 b=0001 -> 8000 after 2 cycles.
REQ-041 out_ready held low for 10 cycles in DONE -> result, flags and out_valid stable, in_ready stays 0; out_ready=1 -> IDLE next cycle.
REQ-042 rst_n asserted during SHIFT of an SLL by 15 -> all outputs reset immediately (asynchronously), and no out_valid follows.
REQ-043 op=111 -> err=1, result 0000, flags unchanged from the prior op.
